// File: rtl/i2c_slave_tx_ctrl.sv
// I2C slave transmit sequencer for master-read transfers: one-entry holding buffer,
// MSB-first shifter, ACK/NACK sampling. Define CLOCK_STRETCH_EN to stretch SCL on underrun.
module i2c_slave_tx_ctrl #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Scl_in,
  input  logic       Sda_in,
  input  logic       Start,
  input  logic       Stop,
  input  logic [7:0] Tx_data,
  input  logic       Tx_valid,
  output logic       Tx_ready,
  output logic       Sda_oe,
  output logic       Scl_oe,
  output logic       Busy,
  output logic       Nack_seen,
  output logic       Underrun
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    ACK
`ifdef CLOCK_STRETCH_EN
    , STRETCH
`endif
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] scl_sync;
  logic [SYNC_STAGES-1:0] sda_sync;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_d;
  logic                   scl_fall;
  logic                   scl_rise;
  logic [7:0]             hold;
  logic                   hold_full;
  logic [7:0]             shifter;
  logic [2:0]             bitcnt;
  logic                   ack_ok;
  logic                   rise_seen;
  logic                   scl_oe_r;
  logic                   accept;
  logic                   bypass;

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign Tx_ready = ~hold_full;
  assign accept   = Tx_valid & ~hold_full;
  assign Busy     = (state != IDLE);
  assign Scl_oe   = scl_oe_r;

`ifdef CLOCK_STRETCH_EN
  // While stretching, an accepted byte goes straight to the shifter instead of the buffer.
  assign bypass = (state == STRETCH) & ~Stop & ~Start;
`else
  assign bypass = 1'b0;
`endif

  // Synchronisers reset to the idle-bus level so reset release creates no edge events.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      scl_fall <= 1'b0;
      scl_rise <= 1'b0;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], Scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], Sda_in};
      scl_d    <= scl_s;
      scl_fall <= scl_d & ~scl_s;
      scl_rise <= ~scl_d & scl_s;
    end
  end

  // NOTE: the payload register needs no reset; hold_full alone says whether it is meaningful.
  always_ff @(posedge Clk) begin
    if (accept) hold <= Tx_data;
  end

  // NOTE: non-blocking assignments everywhere here, so every branch reads pre-edge values.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      shifter   <= '0;
      bitcnt    <= '0;
      hold_full <= 1'b0;
      ack_ok    <= 1'b0;
      rise_seen <= 1'b0;
      Sda_oe    <= 1'b0;
      scl_oe_r  <= 1'b0;
      Nack_seen <= 1'b0;
      Underrun  <= 1'b0;
    end else begin
      Nack_seen <= 1'b0;
      Underrun  <= 1'b0;
      if (accept && !bypass) hold_full <= 1'b1;

      if (Stop) begin
        state    <= IDLE;
        Sda_oe   <= 1'b0;
        scl_oe_r <= 1'b0;
      end else if (Start) begin
        state    <= LOAD;
        Sda_oe   <= 1'b0;
        scl_oe_r <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          LOAD: begin
            bitcnt    <= '0;
            rise_seen <= 1'b0;
            if (hold_full) begin
              shifter   <= hold;
              hold_full <= 1'b0;
              Sda_oe    <= ~hold[7];
              state     <= SHIFT;
            end else begin
`ifdef CLOCK_STRETCH_EN
              scl_oe_r <= 1'b1;
              Sda_oe   <= 1'b0;
              state    <= STRETCH;
`else
              shifter  <= IDLE_BYTE;
              Underrun <= 1'b1;
              Sda_oe   <= ~IDLE_BYTE[7];
              state    <= SHIFT;
`endif
            end
          end
          SHIFT: begin
            if (scl_fall) begin
              if (bitcnt == 3'd7) begin
                Sda_oe    <= 1'b0;
                rise_seen <= 1'b0;
                state     <= ACK;
              end else begin
                shifter <= {shifter[6:0], 1'b0};
                bitcnt  <= bitcnt + 3'd1;
                Sda_oe  <= ~shifter[6];
              end
            end
          end
          ACK: begin
            Sda_oe <= 1'b0;
            // SDA low at the 9th rise is an ACK; the decision waits for the 9th fall.
            if (scl_rise) begin
              ack_ok    <= ~sda_s;
              rise_seen <= 1'b1;
            end else if (scl_fall && rise_seen) begin
              if (ack_ok) begin
                state <= LOAD;
              end else begin
                Nack_seen <= 1'b1;
                state     <= IDLE;
              end
            end
          end
`ifdef CLOCK_STRETCH_EN
          STRETCH: begin
            if (accept) begin
              shifter  <= Tx_data;
              bitcnt   <= '0;
              Sda_oe   <= ~Tx_data[7];
              scl_oe_r <= 1'b0;
              state    <= SHIFT;
            end
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_tx_ctrl.sv
// Self-checking bench for i2c_slave_tx_ctrl: table of single-byte transfers plus directed
// sequences for back-to-back bytes, Stop, Rst, restart and (with CLOCK_STRETCH_EN) stretching.
module tb_i2c_slave_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_in;
  logic       sda_in;
  logic       start;
  logic       stop;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       sda_oe;
  logic       scl_oe;
  logic       busy;
  logic       nack_seen;
  logic       underrun;

`ifdef CLOCK_STRETCH_EN
  localparam bit STRETCH = 1'b1;
`else
  localparam bit STRETCH = 1'b0;
`endif

  int pass_cnt     = 0;
  int total_cnt    = 0;
  int underrun_cnt = 0;
  int nack_cnt     = 0;

  typedef struct {
    logic [7:0] data;
    bit         preload;
    bit         ack;
    logic [7:0] exp_oe;
    int         exp_under;
  } vec_t;

  vec_t vecs[4];

  always #5 clk = ~clk;

  i2c_slave_tx_ctrl dut (
    .Clk      (clk),
    .Rst      (rst),
    .Scl_in   (scl_in),
    .Sda_in   (sda_in),
    .Start    (start),
    .Stop     (stop),
    .Tx_data  (tx_data),
    .Tx_valid (tx_valid),
    .Tx_ready (tx_ready),
    .Sda_oe   (sda_oe),
    .Scl_oe   (scl_oe),
    .Busy     (busy),
    .Nack_seen(nack_seen),
    .Underrun (underrun)
  );

  always @(negedge clk) begin
    if (underrun)  underrun_cnt++;
    if (nack_seen) nack_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic push(input logic [7:0] d);
    int waited = 0;
    tx_data  = d;
    tx_valid = 1'b1;
    while (!tx_ready && waited < 50) begin
      tick(1);
      waited++;
    end
    check("push_ready_timeout", tx_ready, 1);
    tick(1);
    tx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
  endtask

  // One SCL period starting from SCL low: sample Sda_oe late in the low phase,
  // then drive the master's SDA level across the high phase.
  task automatic clock_bit(input logic master_sda, output logic oe_seen);
    tick(6);
    oe_seen = sda_oe;
    sda_in  = master_sda;
    tick(2);
    scl_in = 1'b1;
    tick(8);
    scl_in = 1'b0;
  endtask

  task automatic clock_byte(output logic [7:0] oe_bits);
    logic b;
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, b);
      oe_bits[7-i] = b;
    end
  endtask

  initial begin
    logic [7:0] seen;
    logic       b;
    int         u0, n0, hi_cycles;

    vecs[0] = '{data: 8'hA5, preload: 1'b1, ack: 1'b1, exp_oe: 8'h5A, exp_under: 0};
    vecs[1] = '{data: 8'h3C, preload: 1'b1, ack: 1'b0, exp_oe: 8'hC3, exp_under: 0};
    vecs[2] = '{data: 8'hC3, preload: 1'b1, ack: 1'b1, exp_oe: 8'h3C, exp_under: 0};
    vecs[3] = '{data: 8'h00, preload: 1'b0, ack: 1'b0, exp_oe: 8'h00, exp_under: 1};

    rst = 1'b1; scl_in = 1'b1; sda_in = 1'b1; start = 1'b0; stop = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("reset_sda_oe", sda_oe, 0);
    check("reset_scl_oe", scl_oe, 0);
    check("reset_busy", busy, 0);
    check("reset_nack", nack_seen, 0);
    check("reset_underrun", underrun, 0);
    check("reset_tx_ready", tx_ready, 1);

    // Single-byte transfers from IDLE.
    for (int v = 0; v < 4; v++) begin
      if (!(STRETCH && !vecs[v].preload)) begin
        u0 = underrun_cnt;
        n0 = nack_cnt;
        if (vecs[v].preload) begin
          push(vecs[v].data);
          check("vec_held", tx_ready, 0);
        end
        scl_in = 1'b0;
        tick(6);
        pulse_start();
        tick(1);
        check("vec_first_bit_latency", sda_oe, vecs[v].exp_oe[7]);
        check("vec_busy", busy, 1);
        clock_byte(seen);
        check("vec_bits", seen, vecs[v].exp_oe);
        clock_bit(vecs[v].ack ? 1'b0 : 1'b1, b);
        check("vec_ack_oe", b, 0);
        tick(6);
        sda_in = 1'b1;
        if (vecs[v].ack) begin
          check("vec_ack_reload", busy, 1);
          pulse_stop();
          check("vec_stop_busy", busy, 0);
          check("vec_stop_oe", sda_oe, 0);
        end else begin
          check("vec_nack_pulses", nack_cnt - n0, 1);
          check("vec_nack_idle", busy, 0);
        end
        check("vec_underruns", underrun_cnt - u0,
              vecs[v].exp_under + ((vecs[v].ack && !STRETCH) ? 1 : 0));
      end
    end

    // Two queued bytes: ACK the first, NACK the second.
    u0 = underrun_cnt;
    n0 = nack_cnt;
    push(8'h3C);
    tick(6);
    pulse_start();
    tick(1);
    push(8'hC3);
    clock_byte(seen);
    check("two_byte_first", seen, 8'hC3);
    clock_bit(1'b0, b);
    check("two_byte_ack_oe", b, 0);
    clock_byte(seen);
    check("two_byte_second", seen, 8'h3C);
    check("two_byte_no_early_nack", nack_cnt - n0, 0);
    clock_bit(1'b1, b);
    tick(6);
    sda_in = 1'b1;
    check("two_byte_nack_once", nack_cnt - n0, 1);
    check("two_byte_idle", busy, 0);
    check("two_byte_no_underrun", underrun_cnt - u0, 0);

    // Stop after the third data bit of 8'h00.
    push(8'h00);
    tick(6);
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      clock_bit(1'b1, b);
      check("stop_seq_bit", b, 1);
    end
    tick(6);
    check("stop_seq_oe_before", sda_oe, 1);
    pulse_stop();
    check("stop_seq_oe", sda_oe, 0);
    check("stop_seq_busy", busy, 0);
    push(8'h5A);
    tick(2);
    check("stop_seq_byte_held", tx_ready, 0);

    // Rst during SHIFT with a byte held.
    pulse_start();
    tick(1);
    check("rst_seq_first_bit", sda_oe, 1);
    push(8'h7E);
    clock_bit(1'b1, b);
    clock_bit(1'b1, b);
    check("rst_seq_held", tx_ready, 0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst_seq_sda_oe", sda_oe, 0);
    check("rst_seq_scl_oe", scl_oe, 0);
    check("rst_seq_busy", busy, 0);
    check("rst_seq_nack", nack_seen, 0);
    check("rst_seq_underrun", underrun, 0);
    check("rst_seq_tx_ready", tx_ready, 1);

    // Repeated start mid-byte, then Start and Stop together.
    tick(2);
    push(8'h11);
    tick(6);
    pulse_start();
    tick(1);
    check("restart_first_byte_bit", sda_oe, 1);
    push(8'hE7);
    clock_bit(1'b1, b);
    clock_bit(1'b1, b);
    tick(6);
    pulse_start();
    tick(1);
    check("restart_new_bit", sda_oe, 0);
    check("restart_busy", busy, 1);
    clock_byte(seen);
    check("restart_bits", seen, 8'h18);
    tick(6);
    start = 1'b1;
    stop  = 1'b1;
    tick(1);
    start = 1'b0;
    stop  = 1'b0;
    check("start_stop_busy", busy, 0);
    check("start_stop_oe", sda_oe, 0);

`ifdef CLOCK_STRETCH_EN
    // Empty buffer at LOAD stretches SCL until a byte arrives.
    u0 = underrun_cnt;
    n0 = nack_cnt;
    pulse_start();
    tick(1);
    hi_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (scl_oe === 1'b1 && sda_oe === 1'b0) hi_cycles++;
      tick(1);
    end
    check("stretch_held_cycles", hi_cycles, 20);
    tx_data  = 8'h81;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    check("stretch_release", scl_oe, 0);
    check("stretch_first_bit", sda_oe, 0);
    check("stretch_bypass", tx_ready, 1);
    clock_byte(seen);
    check("stretch_bits", seen, 8'h7E);
    clock_bit(1'b1, b);
    tick(6);
    sda_in = 1'b1;
    check("stretch_nack", nack_cnt - n0, 1);
    check("stretch_no_underrun", underrun_cnt - u0, 0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
